// File: rtl/axis_corr_sched.sv
// Correlator bank scheduler: broadcasts input beats to enabled lanes and
// collects one result per enabled lane, in ascending lane order, onto a tagged stream.
module axis_corr_sched #(
   parameter int NUM_CORR     = 4,
   parameter int SLAVE_WIDTH  = 64,
   parameter int MASTER_WIDTH = 128,
   parameter int MAX_PENDING  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic [SLAVE_WIDTH-1:0]           s_axis_tdata,
   output logic [NUM_CORR-1:0]              c_axis_tvalid,
   input  logic [NUM_CORR-1:0]              c_axis_tready,
   output logic [SLAVE_WIDTH-1:0]           c_axis_tdata,
   input  logic [NUM_CORR-1:0]              r_axis_tvalid,
   output logic [NUM_CORR-1:0]              r_axis_tready,
   input  logic [NUM_CORR*MASTER_WIDTH-1:0] r_axis_tdata,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [MASTER_WIDTH-1:0]          m_axis_tdata,
   output logic [3:0]                       m_axis_tuser,
   output logic                             m_axis_tlast,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [NUM_CORR-1:0]              cfg_mask,
   output logic [3:0]                       pending
);

   localparam int IW = (NUM_CORR > 1) ? $clog2(NUM_CORR) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t              state;
   logic [NUM_CORR-1:0] mask_q;
   logic [NUM_CORR-1:0] acc;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       lo;
   logic [IW-1:0]       hi;
   logic [IW-1:0]       nxt;
   logic                room;
   logic                s_hs;
   logic                out_free;
   logic                sel_rdy;
   logic                r_hs;
   logic                done;
   logic [3:0]          pend_nxt;

   assign room          = pending < 4'(MAX_PENDING);
   assign c_axis_tvalid = {NUM_CORR{s_axis_tvalid & room}} & mask_q & ~acc;
   assign c_axis_tdata  = s_axis_tdata;
   assign s_axis_tready = room & (|mask_q) & (&(acc | c_axis_tready | ~mask_q));
   assign s_hs          = s_axis_tvalid & s_axis_tready;

   // lowest, highest and next-above-idx enabled lanes
   always_comb begin
      lo  = '0;
      hi  = '0;
      nxt = '0;
      for (int j = NUM_CORR - 1; j >= 0; j--) begin
         if (mask_q[j]) lo = IW'(j);
         if (mask_q[j] && j > int'(idx)) nxt = IW'(j);
      end
      for (int j = 0; j < NUM_CORR; j++) begin
         if (mask_q[j]) hi = IW'(j);
      end
   end

   assign out_free = ~m_axis_tvalid | m_axis_tready;
   assign sel_rdy  = (state == SCAN) & out_free & mask_q[idx];
   assign r_hs     = sel_rdy & r_axis_tvalid[idx];
   assign done     = r_hs & (idx == hi);
   assign pend_nxt = pending + {3'b000, s_hs} - {3'b000, done};

   always_comb begin
      r_axis_tready      = '0;
      r_axis_tready[idx] = sel_rdy;
   end

   assign cfg_ready = (pending == 4'd0) & (acc == '0) & (state == IDLE)
                    & ~m_axis_tvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         mask_q        <= '1;
         acc           <= '0;
         idx           <= '0;
         pending       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (cfg_valid && cfg_ready) mask_q <= cfg_mask;
         if (s_hs) acc <= '0;
         else      acc <= acc | (c_axis_tvalid & c_axis_tready);
         pending <= pend_nxt;
         if (r_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= r_axis_tdata[int'(idx)*MASTER_WIDTH +: MASTER_WIDTH];
            m_axis_tuser  <= 4'(idx);
            m_axis_tlast  <= (idx == hi);
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (pending != 4'd0) begin
                  state <= SCAN;
                  idx   <= lo;
               end
            end
            SCAN: begin
               if (done) begin
                  idx   <= lo;
                  state <= (pend_nxt != 4'd0) ? SCAN : IDLE;
               end else if (r_hs) begin
                  idx <= nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_corr_sched.sv
// Bench for axis_corr_sched: lane models, a result scoreboard built from the
// broadcast beats, a directed table, multi-cycle corner sequences and random traffic.
module tb_axis_corr_sched;

   localparam int NC = 4;
   localparam int SW = 64;
   localparam int MW = 128;
   localparam int MP = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic [SW-1:0]    s_axis_tdata;
   logic [NC-1:0]    c_axis_tvalid;
   logic [NC-1:0]    c_axis_tready;
   logic [SW-1:0]    c_axis_tdata;
   logic [NC-1:0]    r_axis_tvalid;
   logic [NC-1:0]    r_axis_tready;
   logic [NC*MW-1:0] r_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic [MW-1:0]    m_axis_tdata;
   logic [3:0]       m_axis_tuser;
   logic             m_axis_tlast;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [NC-1:0]    cfg_mask;
   logic [3:0]       pending;

   always #5 clk = ~clk;

   axis_corr_sched #(
      .NUM_CORR(NC), .SLAVE_WIDTH(SW), .MASTER_WIDTH(MW), .MAX_PENDING(MP)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata),
      .c_axis_tvalid(c_axis_tvalid), .c_axis_tready(c_axis_tready),
      .c_axis_tdata(c_axis_tdata),
      .r_axis_tvalid(r_axis_tvalid), .r_axis_tready(r_axis_tready),
      .r_axis_tdata(r_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mask(cfg_mask),
      .pending(pending)
   );

   typedef struct {
      logic [3:0]    tuser;
      logic [MW-1:0] data;
      logic          last;
   } res_t;

   typedef struct {
      logic [NC-1:0] mask;
      logic [SW-1:0] beat;
      int            cnt;
      logic [3:0]    first;
      logic [3:0]    last_lane;
   } vec_t;

   res_t exp_q[$];
   res_t log_q[$];

   int errors = 0;
   int checks = 0;

   int            c_pct = 100;
   int            r_pct = 100;
   int            m_pct = 100;
   logic [NC-1:0] c_block = '0;
   bit            junk = 1'b0;

   logic [NC-1:0] mask_model;
   logic [NC-1:0] lane_got;
   logic [SW-1:0] lane_mem [NC][16];
   int            wp [NC];
   int            rp [NC];

   logic          snap_s_hs;
   logic          snap_cfg_hs;
   logic          snap_s_ready;
   logic          snap_cfg_ready;
   logic          snap_m_valid;
   logic [NC-1:0] snap_c_valid;
   logic [3:0]    snap_pending;

   // what correlator lane "lane" returns for beat b
   function automatic logic [MW-1:0] lane_res(input int lane, input logic [SW-1:0] b);
      return {b ^ (64'h0101_0101_0101_0101 * 64'(lane + 1)), ~b ^ 64'(lane)};
   endfunction

   task automatic chk(input bit ok, input string name,
                      input logic [MW-1:0] act, input logic [MW-1:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      log_q.delete();
      mask_model = '1;
      lane_got   = '0;
      for (int i = 0; i < NC; i++) begin
         wp[i] = 0;
         rp[i] = 0;
      end
   endtask

   // sampled just before the rising edge: settled handshakes for that edge
   task automatic observe();
      res_t e;
      snap_s_hs      = s_axis_tvalid & s_axis_tready;
      snap_cfg_hs    = cfg_valid & cfg_ready;
      snap_s_ready   = s_axis_tready;
      snap_cfg_ready = cfg_ready;
      snap_m_valid   = m_axis_tvalid;
      snap_c_valid   = c_axis_tvalid;
      snap_pending   = pending;
      if (rst) return;
      for (int i = 0; i < NC; i++) begin
         if (c_axis_tvalid[i]) chk(mask_model[i], "c_valid_disabled", i, mask_model);
         if (c_axis_tvalid[i] && c_axis_tready[i]) begin
            chk(!lane_got[i], "c_duplicate", i, lane_got);
            chk(c_axis_tdata == s_axis_tdata, "c_data", c_axis_tdata, s_axis_tdata);
            lane_got[i] = 1'b1;
            lane_mem[i][wp[i] % 16] = s_axis_tdata;
            wp[i]++;
         end
      end
      if (snap_s_hs) begin
         chk(lane_got == mask_model, "broadcast_lanes", lane_got, mask_model);
         lane_got = '0;
         for (int i = 0; i < NC; i++) begin
            if (mask_model[i]) begin
               e.tuser = 4'(i);
               e.data  = lane_res(i, s_axis_tdata);
               e.last  = ((mask_model >> (i + 1)) == '0);
               exp_q.push_back(e);
            end
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (r_axis_tready[i]) chk(mask_model[i], "r_ready_disabled", i, mask_model);
         if (r_axis_tready[i] && r_axis_tvalid[i] && mask_model[i]) rp[i]++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "m_unexpected", m_axis_tuser, 0);
         end else begin
            e = exp_q.pop_front();
            chk(m_axis_tuser == e.tuser, "m_tuser", m_axis_tuser, e.tuser);
            chk(m_axis_tdata == e.data, "m_tdata", m_axis_tdata, e.data);
            chk(m_axis_tlast == e.last, "m_tlast", m_axis_tlast, e.last);
         end
         e.tuser = m_axis_tuser;
         e.data  = m_axis_tdata;
         e.last  = m_axis_tlast;
         log_q.push_back(e);
      end
      chk(pending <= 4'(MP), "pending_max", pending, MP);
      if (snap_cfg_hs) mask_model = cfg_mask;
   endtask

   task automatic tick();
      #4;
      observe();
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
         c_axis_tready[i] = !c_block[i] && (int'($urandom_range(99)) < c_pct);
         if (mask_model[i]) begin
            r_axis_tvalid[i] = (rp[i] != wp[i]) && (int'($urandom_range(99)) < r_pct);
            r_axis_tdata[i*MW +: MW] = lane_res(i, lane_mem[i][rp[i] % 16]);
         end else begin
            r_axis_tvalid[i] = junk;
            r_axis_tdata[i*MW +: MW] = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      m_axis_tready = int'($urandom_range(99)) < m_pct;
   endtask

   task automatic cfg_set(input logic [NC-1:0] m);
      bit got = 1'b0;
      cfg_valid = 1'b1;
      cfg_mask  = m;
      for (int k = 0; k < 200 && !got; k++) begin
         tick();
         got = snap_cfg_hs;
      end
      cfg_valid = 1'b0;
      chk(got, "cfg_timeout", got, 1);
   endtask

   task automatic send_beat(input logic [SW-1:0] d);
      bit got = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      for (int k = 0; k < 200 && !got; k++) begin
         tick();
         got = snap_s_hs;
      end
      s_axis_tvalid = 1'b0;
      chk(got, "send_timeout", got, 1);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int k = 0; k < 500 && !ok; k++) begin
         tick();
         ok = (exp_q.size() == 0) && !m_axis_tvalid && (pending == 4'd0);
      end
      chk(ok, "drain_timeout", exp_q.size(), 0);
   endtask

   vec_t tbl [5];

   initial begin
      int sent;
      int nlast;
      bit got;

      tbl[0] = '{4'hF, 64'hA5A5_A5A5_A5A5_A5A5, 4, 4'd0, 4'd3};
      tbl[1] = '{4'hA, 64'h0123_4567_89AB_CDEF, 2, 4'd1, 4'd3};
      tbl[2] = '{4'h1, 64'hDEAD_BEEF_0000_0001, 1, 4'd0, 4'd0};
      tbl[3] = '{4'h8, 64'hFFFF_0000_FFFF_0000, 1, 4'd3, 4'd3};
      tbl[4] = '{4'h6, 64'h5555_AAAA_5555_AAAA, 2, 4'd1, 4'd2};

      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      c_axis_tready = '0;
      r_axis_tvalid = '0;
      r_axis_tdata  = '0;
      m_axis_tready = 1'b1;
      cfg_valid     = 1'b0;
      cfg_mask      = '0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();

      chk(m_axis_tvalid == 1'b0, "rst_m_valid", m_axis_tvalid, 0);
      chk(pending == 4'd0, "rst_pending", pending, 0);
      chk(cfg_ready == 1'b1, "rst_cfg_ready", cfg_ready, 1);
      chk(m_axis_tuser == 4'd0, "rst_tuser", m_axis_tuser, 0);
      chk(m_axis_tlast == 1'b0, "rst_tlast", m_axis_tlast, 0);
      chk(m_axis_tdata == '0, "rst_tdata", m_axis_tdata, 0);
      chk(c_axis_tvalid == '0, "rst_c_valid", c_axis_tvalid, 0);

      // one beat per mask: result order and tlast placement
      junk = 1'b1;
      for (int t = 0; t < 5; t++) begin
         cfg_set(tbl[t].mask);
         log_q.delete();
         send_beat(tbl[t].beat);
         drain();
         chk(log_q.size() == tbl[t].cnt, "tbl_count", log_q.size(), tbl[t].cnt);
         if (log_q.size() > 0) begin
            chk(log_q[0].tuser == tbl[t].first, "tbl_first", log_q[0].tuser, tbl[t].first);
            chk(log_q[$].tuser == tbl[t].last_lane && log_q[$].last, "tbl_last",
                log_q[$].tuser, tbl[t].last_lane);
         end
         nlast = 0;
         foreach (log_q[k]) if (log_q[k].last) nlast++;
         chk(nlast == 1, "tbl_one_tlast", nlast, 1);
      end
      junk = 1'b0;

      // lane 2 holds off: others accept early, beat completes only with lane 2
      cfg_set(4'hF);
      c_block = 4'b0100;
      tick();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'h1357_9BDF_2468_ACE0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk(!snap_s_ready, "lane2_stall_ready", snap_s_ready, 0);
         chk(snap_c_valid[2], "lane2_stall_valid", snap_c_valid, 4'b0100);
      end
      chk(snap_c_valid == 4'b0100, "lane2_only_left", snap_c_valid, 4'b0100);
      c_block = '0;
      got = 1'b0;
      for (int k = 0; k < 5 && !got; k++) begin
         tick();
         got = snap_s_hs;
      end
      s_axis_tvalid = 1'b0;
      chk(got, "lane2_release", got, 1);
      drain();

      // zero mask stalls input
      cfg_set(4'h0);
      s_axis_tvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk(!snap_s_ready && snap_c_valid == '0, "zero_mask_stall", snap_c_valid, 0);
      end
      s_axis_tvalid = 1'b0;
      cfg_set(4'hF);

      // output back-pressure: pending saturates, nothing lost
      log_q.delete();
      m_pct = 0;
      tick();
      sent = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      for (int k = 0; k < 15; k++) begin
         tick();
         if (snap_s_hs) begin
            sent++;
            s_axis_tdata = {$urandom, $urandom};
         end
      end
      chk(sent == MP, "bp_accepted", sent, MP);
      chk(snap_pending == 4'(MP), "bp_pending", snap_pending, MP);
      chk(!snap_s_ready, "bp_s_ready", snap_s_ready, 0);
      m_pct = 100;
      for (int k = 0; k < 200 && sent < 6; k++) begin
         tick();
         if (snap_s_hs) begin
            sent++;
            s_axis_tdata = {$urandom, $urandom};
         end
      end
      s_axis_tvalid = 1'b0;
      chk(sent == 6, "bp_all_sent", sent, 6);
      drain();
      chk(log_q.size() == 24, "bp_results", log_q.size(), 24);

      // config requested with two beats outstanding
      m_pct = 0;
      tick();
      send_beat({$urandom, $urandom});
      send_beat({$urandom, $urandom});
      log_q.delete();
      cfg_valid = 1'b1;
      cfg_mask  = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk(!snap_cfg_ready && !snap_cfg_hs, "cfg_blocked", snap_cfg_ready, 0);
      end
      chk(snap_pending == 4'd2, "cfg_pending2", snap_pending, 2);
      m_pct = 100;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         tick();
         got = snap_cfg_hs;
      end
      cfg_valid = 1'b0;
      chk(got, "cfg_after_drain", got, 1);
      chk(log_q.size() == 8, "cfg_sweeps_done", log_q.size(), 8);
      log_q.delete();
      send_beat({$urandom, $urandom});
      drain();
      chk(log_q.size() == 2, "cfg_new_mask", log_q.size(), 2);

      // reset in the middle of a sweep
      cfg_set(4'hF);
      m_pct = 0;
      tick();
      send_beat({$urandom, $urandom});
      send_beat({$urandom, $urandom});
      tick();
      tick();
      c_block = '1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      s_axis_tvalid = 1'b1;
      tick();
      chk(!snap_m_valid, "midrst_m_valid", snap_m_valid, 0);
      chk(snap_pending == 4'd0, "midrst_pending", snap_pending, 0);
      chk(snap_c_valid == 4'hF, "midrst_mask", snap_c_valid, 4'hF);
      s_axis_tvalid = 1'b0;
      c_block = '0;
      m_pct = 100;
      drain();

      // random traffic against the scoreboard
      c_pct = 70;
      r_pct = 60;
      m_pct = 70;
      for (int round = 0; round < 4; round++) begin
         for (int cyc = 0; cyc < 500; cyc++) begin
            if (!s_axis_tvalid && ($urandom_range(2) == 0)) begin
               s_axis_tvalid = 1'b1;
               s_axis_tdata  = {$urandom, $urandom};
            end
            tick();
            if (snap_s_hs) s_axis_tvalid = 1'b0;
         end
         got = !s_axis_tvalid;
         for (int k = 0; k < 200 && !got; k++) begin
            tick();
            got = snap_s_hs;
         end
         s_axis_tvalid = 1'b0;
         chk(got, "rand_last_beat", got, 1);
         drain();
         cfg_set(NC'($urandom_range(15, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
